// File: rtl/demux_serial_driver.sv
// Serialises a parallel word LSB-first for a 1:4 serial demux, holding the channel select for the frame.
// Define DEMUX_SERIAL_PARITY_EN to append an even-parity bit after the last data bit.
module demux_serial_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       chan_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             Din,
    output logic [1:0]       sel,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef DEMUX_SERIAL_PARITY_EN
        PARITY = 2'd2,
`endif
        SHIFT  = 2'd1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

`ifdef DEMUX_SERIAL_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    assign cnt_nxt   = cnt + CNT_W'(1);
    assign ready_out = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            Din   <= 1'b0;
            sel   <= 2'b00;
            done  <= 1'b0;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    Din <= 1'b0;
                    // sel only moves here, so it stays put for the whole frame and afterwards
                    if (valid_in) begin
                        shreg <= data_in;
                        sel   <= chan_in;
                        Din   <= data_in[0];
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        Din <= shreg[cnt_nxt];
                        cnt <= cnt_nxt;
                    end else begin
`ifdef DEMUX_SERIAL_PARITY_EN
                        Din   <= even_parity(shreg);
                        state <= PARITY;
`else
                        Din   <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
`endif
                    end
                end
`ifdef DEMUX_SERIAL_PARITY_EN
                PARITY: begin
                    Din   <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
`endif
                default: begin
                    Din   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_serial_driver.sv
// Directed bench for demux_serial_driver (WIDTH=8); parity expectations follow DEMUX_SERIAL_PARITY_EN.
module tb_demux_serial_driver;

    localparam int W = 8;
`ifdef DEMUX_SERIAL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN = W + PAR;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] data_in;
    logic [1:0]   chan_in;
    logic         valid_in;
    logic         ready_out;
    logic         din;
    logic [1:0]   sel;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    demux_serial_driver #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .chan_in  (chan_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .Din      (din),
        .sel      (sel),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        chan_in  = 2'b00;
        #1 rst_n = 1'b0;
        valid_in = 1'b1;
        data_in  = 8'hFF;
        chan_in  = 2'b11;
        step();
        step();
        n_cmp++;
        if ({din, sel, ready_out, done} !== {1'b0, 2'b00, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_hold: got din=%b sel=%b rdy=%b done=%b, want 0 00 1 0", din, sel, ready_out, done);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        valid_in = 1'b0;
        step();
        n_cmp++;
        if ({din, sel, ready_out, done} !== {1'b0, 2'b00, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_release: got din=%b sel=%b rdy=%b done=%b, want 0 00 1 0", din, sel, ready_out, done);
        end
    endtask

    task automatic test_single();
        logic [W-1:0] d   = 8'hA5;
        logic [W-1:0] seq = 8'b1010_0101;  // Din order, LSB first: 1,0,1,0,0,1,0,1
        logic         e;
        data_in  = d;
        chan_in  = 2'b10;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 1; i <= FLEN; i++) begin
            if (i > 1) step();
            e = (i <= W) ? seq[i-1] : 1'b0;  // parity of A5 is 0
            n_cmp++;
            if ({din, sel, ready_out, done} !== {e, 2'b10, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL single_c%0d: got din=%b sel=%b rdy=%b done=%b, want din=%b sel=10 rdy=0 done=0",
                         i, din, sel, ready_out, done, e);
            end
        end
        step();
        n_cmp++;
        if ({din, sel, ready_out, done} !== {1'b0, 2'b10, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL single_done: got din=%b sel=%b rdy=%b done=%b, want 0 10 1 1", din, sel, ready_out, done);
        end
    endtask

    task automatic test_back_to_back();
        int first_done;
        data_in  = 8'hFF;
        chan_in  = 2'b01;
        valid_in = 1'b1;
        step();
        data_in  = 8'h00;
        chan_in  = 2'b11;
        for (int i = 1; i <= FLEN; i++) begin
            if (i > 1) step();
            n_cmp++;
            if ({din, sel, ready_out, done} !== {(i <= W), 2'b01, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL b2b_a_c%0d: got din=%b sel=%b rdy=%b done=%b, want din=%b sel=01 rdy=0 done=0",
                         i, din, sel, ready_out, done, (i <= W));
            end
        end
        step();
        first_done = cyc;
        n_cmp++;
        if ({din, sel, ready_out, done} !== {1'b0, 2'b01, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_gap: got din=%b sel=%b rdy=%b done=%b, want 0 01 1 1", din, sel, ready_out, done);
        end
        for (int i = 1; i <= FLEN; i++) begin
            step();
            if (i == 1) valid_in = 1'b0;
            n_cmp++;
            if ({din, sel, ready_out, done} !== {1'b0, 2'b11, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL b2b_b_c%0d: got din=%b sel=%b rdy=%b done=%b, want 0 11 0 0",
                         i, din, sel, ready_out, done);
            end
        end
        step();
        n_cmp++;
        if ({done, ready_out} !== 2'b11 || (cyc - first_done) != FLEN + 1) begin
            n_bad++;
            $display("FAIL b2b_done2: got done=%b rdy=%b spacing=%0d, want done=1 rdy=1 spacing=%0d",
                     done, ready_out, cyc - first_done, FLEN + 1);
        end
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] d = 8'h5A;
        logic         e;
        data_in  = d;
        chan_in  = 2'b01;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 1; i <= FLEN; i++) begin
            if (i > 1) step();
            if (i == 5) begin
                valid_in = 1'b0;
                data_in  = d;
                chan_in  = 2'b01;
            end
            e = (i <= W) ? d[i-1] : 1'b0;  // parity of 5A is 0
            n_cmp++;
            if ({din, sel, ready_out, done} !== {e, 2'b01, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL busy_c%0d: got din=%b sel=%b rdy=%b done=%b, want din=%b sel=01 rdy=0 done=0",
                         i, din, sel, ready_out, done, e);
            end
            if (i == 4) begin
                valid_in = 1'b1;
                data_in  = 8'h3C;
                chan_in  = 2'b00;
            end
        end
        step();
        n_cmp++;
        if ({din, sel, ready_out, done} !== {1'b0, 2'b01, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL busy_done: got din=%b sel=%b rdy=%b done=%b, want 0 01 1 1", din, sel, ready_out, done);
        end
        step();
        n_cmp++;
        if ({din, sel, ready_out, done} !== {1'b0, 2'b01, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL busy_noqueue: got din=%b sel=%b rdy=%b done=%b, want 0 01 1 0", din, sel, ready_out, done);
        end
    endtask

    task automatic test_input_hold();
        logic [W-1:0] d = 8'h4B;
        logic         e;
        data_in  = d;
        chan_in  = 2'b10;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        data_in  = 8'hB4;
        chan_in  = 2'b01;
        for (int i = 1; i <= FLEN; i++) begin
            if (i > 1) step();
            e = (i <= W) ? d[i-1] : 1'b0;  // parity of 4B is 0
            n_cmp++;
            if ({din, sel} !== {e, 2'b10}) begin
                n_bad++;
                $display("FAIL hold_c%0d: got din=%b sel=%b, want din=%b sel=10", i, din, sel, e);
            end
        end
        step();
        n_cmp++;
        if ({din, done} !== 2'b01) begin
            n_bad++;
            $display("FAIL hold_done: got din=%b done=%b, want 0 1", din, done);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] d2 = 8'h96;
        logic         e;
        data_in  = 8'hC3;
        chan_in  = 2'b11;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({din, sel, done} !== {1'b0, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL rstmid_async: got din=%b sel=%b done=%b, want 0 00 0", din, sel, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if ({din, sel, ready_out, done} !== {1'b0, 2'b00, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL rstmid_release: got din=%b sel=%b rdy=%b done=%b, want 0 00 1 0", din, sel, ready_out, done);
        end
        data_in  = d2;
        chan_in  = 2'b10;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 1; i <= FLEN; i++) begin
            if (i > 1) step();
            e = (i <= W) ? d2[i-1] : 1'b0;  // parity of 96 is 0
            n_cmp++;
            if ({din, sel, ready_out} !== {e, 2'b10, 1'b0}) begin
                n_bad++;
                $display("FAIL rstmid_next_c%0d: got din=%b sel=%b rdy=%b, want din=%b sel=10 rdy=0",
                         i, din, sel, ready_out, e);
            end
        end
        step();
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_next_done: got done=%b, want 1", done);
        end
    endtask

`ifdef DEMUX_SERIAL_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] words [2] = '{8'h07, 8'hA5};
        logic         pbit  [2] = '{1'b1, 1'b0};
        logic         e;
        for (int w = 0; w < 2; w++) begin
            data_in  = words[w];
            chan_in  = 2'b00;
            valid_in = 1'b1;
            step();
            valid_in = 1'b0;
            for (int i = 1; i <= W + 1; i++) begin
                if (i > 1) step();
                e = (i <= W) ? words[w][i-1] : pbit[w];
                n_cmp++;
                if ({din, sel, done} !== {e, 2'b00, 1'b0}) begin
                    n_bad++;
                    $display("FAIL parity_w%0d_c%0d: got din=%b sel=%b done=%b, want din=%b sel=00 done=0",
                             w, i, din, sel, done, e);
                end
            end
            step();
            n_cmp++;
            if ({din, done, ready_out} !== 3'b011) begin
                n_bad++;
                $display("FAIL parity_w%0d_done: got din=%b done=%b rdy=%b, want 0 1 1", w, din, done, ready_out);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_ignore();
        test_input_hold();
        test_reset_mid_frame();
`ifdef DEMUX_SERIAL_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/demux_serial_driver.md
Name: demux_serial_driver

Overview:
- Upstream feeder for the 1:4 serial demultiplexer stage.
- Accepts a parallel word plus a 2-bit target channel over a valid/ready handshake.
- Serialises the word LSB-first onto a 1-bit data line and holds the channel select stable for the whole frame, so the downstream demux routes every bit of the frame to one output.
- Idle line level is 0, so all demux outputs read 0 between frames.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  WIDTH  word to serialise.
- chan_in  input  2  target demux channel, 0..3.
- valid_in  input  1  data_in/chan_in valid.
- ready_out  output  1  block can accept a word.
- Din  output  1  registered serial data to the demux data input.
- sel  output  2  registered channel select to the demux select input.
- done  output  1  one-cycle pulse after the final bit of a frame.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately including mid-frame):
  - state=IDLE, Din=0, sel=2'b00, done=0, bit counter=0, shift register=0.
  - Any frame in progress is abandoned; nothing resumes after release.
  - No transfer is accepted while rst_n is low.
- ready_out = (state==IDLE). It is combinational from state only, with no path from valid_in.
- Handshake: a transfer occurs on a rising edge where valid_in && ready_out.
  - valid_in while ready_out=0 is ignored; there is no queuing.
- States:
  - IDLE:
    - Din=0; sel holds its last value.
    - On transfer: shift register<=data_in, sel<=chan_in, Din<=data_in[0], counter<=0, go to SHIFT.
  - SHIFT:
    - On each edge, if counter<WIDTH-1: Din<=shreg[counter+1], counter<=counter+1.
    - If counter==WIDTH-1: go to PARITY when the feature is enabled, else Din<=0, done<=1, go to IDLE.
  - PARITY (feature only):
    - Din carries the parity bit for one cycle.
    - Next edge: Din<=0, done<=1, go to IDLE.
- Timing with transfer at edge E:
  - Bit k is on Din during the cycle after edge E+k, for k=0..WIDTH-1.
  - sel is valid from the cycle after E through the last data (or parity) cycle, and stays held afterwards.
  - done is high for exactly one cycle: the first IDLE cycle, in which ready_out=1.
- Back-to-back:
  - A transfer in the done cycle is legal.
  - Frame period is WIDTH+1 cycles (WIDTH+2 with parity), with exactly one Din=0 gap cycle.
  - sel changes only at a transfer edge, never mid-frame.
- data_in/chan_in changes after the transfer edge have no effect on the frame in flight.
- done is cleared to 0 on every edge where it is not being set.
- Counter width is clog2(WIDTH); it never exceeds WIDTH-1.

Optional Feature:
- Macro DEMUX_SERIAL_PARITY_EN.
- Defined:
  - The PARITY state exists.
  - After bit WIDTH-1, one extra cycle carries the even-parity bit (XOR of the latched word) on Din, with sel still held.
  - done is then asserted one cycle later than without the macro.
- Undefined:
  - No PARITY state and no parity logic.
  - done follows the last data bit directly.

Test Plan:
- Reset mid-frame: pull rst_n low in the 4th bit cycle of a frame.
  - Required: Din=0, sel=00, done=0 immediately, ready_out=1 after release.
  - Required: the next accepted word is sent complete.
- Single frame, WIDTH=8, data_in=8'hA5, chan_in=2, no parity.
  - Required: Din sequence 1,0,1,0,0,1,0,1 over 8 cycles with sel=2'b10 throughout.
  - Required: done=1 in cycle 9, ready_out=0 during cycles 1-8.
- Back-to-back: 8'hFF ch1 then 8'h00 ch3, with valid_in held high.
  - Required: eight 1s with sel=01, one gap cycle with Din=0 and done=1, then eight 0s with sel=11.
  - Required: the second done follows 9 cycles after the first.
- Busy ignore: pulse valid_in with 8'h3C ch0 during bit 3 of a frame.
  - Required: not accepted, the current frame is unchanged, sel is unchanged.
- Parity (DEMUX_SERIAL_PARITY_EN): 8'h07 ch0.
  - Required: Din 1,1,1,0,0,0,0,0 then parity bit 1, with done in cycle 10.
  - Required: 8'hA5 gives parity bit 0.
- Input hold: change data_in and chan_in on the cycle after the transfer edge.
  - Required: the serialised bits and sel still match the values latched at the transfer edge.
